imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
// Shares the single backing-memory port between the instruction-cache refill path
// (fetch side) and the data-cache miss/writeback path (LSU side).
// One transaction is in flight at a time. The arbiter owns the request/response handshake
// to memory and routes each response back to the requester that issued it.
// It also supports fetch-redirect flushing: an in-flight I-side response is discarded
// when the front end is redirected.
// PARAMETERS
// ADDR_W   32  address width, all ports
// LINE_W   32  data width of memory responses and D-side write data (FETCH_WIDTH*32)
// RR_EN    1   1 = round-robin between I and D; 0 = fixed priority, D-side wins
// PORTS
// clock          in   1       clock
// reset          in   1       synchronous, active-high reset
// ic_req_valid   in   1       I-side read request pending; held until ic_req_ready
// ic_req_addr    in   ADDR_W  I-side read address, stable while ic_req_valid
// ic_req_ready   out  1       1-cycle pulse: I-side request accepted
// ic_flush       in   1       front-end redirect; discard any pending I-side response
// ic_resp_valid  out  1       1-cycle pulse: ic_resp_data valid
// ic_resp_data   out  LINE_W  I-side read data
// dc_req_valid   in   1       D-side request pending; held until dc_req_ready
// dc_req_addr    in   ADDR_W  D-side address
// dc_req_we      in   1       1 = write, 0 = read
// dc_req_wdata   in   LINE_W  D-side write data
// dc_req_ready   out  1       1-cycle pulse: D-side request accepted
// dc_resp_valid  out  1       1-cycle pulse: read data, or write ack
// dc_resp_data   out  LINE_W  D-side read data (write: mem_resp_data passed through)
// mem_req_valid  out  1       memory request valid; held until mem_req_ready
// mem_req_addr   out  ADDR_W  memory address
// mem_req_we     out  1       memory write enable
// mem_req_wdata  out  LINE_W  memory write data
// mem_req_ready  in   1       memory accepts request when mem_req_valid & mem_req_ready
// mem_resp_valid in   1       memory response; one per accepted request
// mem_resp_data  in   LINE_W  memory response data
// BEHAVIOUR
// - Reset behaviour:
//   - All outputs are 0; state=IDLE; last_grant=D (so I-side wins the first tie); drop=0.
//   - A reset mid-transaction abandons it. The memory side is reset with the same signal.
// - All outputs are registered. State machine:
//   - IDLE -> REQ when any req_valid is high. Grant is decided in that cycle; the granted
//     requester gets req_ready=1 in the next cycle.
//   - REQ: mem_req_valid=1, with addr/we/wdata latched from the winner. Moves to WAIT in the
//     cycle after mem_req_valid & mem_req_ready. Signals are held, never withdrawn.
//   - WAIT: waits for mem_resp_valid. The next cycle the owner gets resp_valid=1 plus the
//     latched data, and state returns to IDLE.
//   - A new grant is possible in the IDLE cycle that directly follows the response pulse.
// - Arbitration:
//   - RR_EN=1: when both requesters are valid, the grant goes to the one not equal to
//     last_grant. A single valid requester always wins.
//   - RR_EN=0: D-side always wins.
//   - last_grant updates on every grant.
// - Minimum latency (mem_req_ready=1 and 1-cycle memory):
//   - Request sampled at cycle N -> req_ready and mem_req_valid at N+1.
//   - mem_resp_valid at N+2 -> resp_valid at N+3.
// - Requester handshake:
//   - A requester must keep req_valid high until it sees req_ready.
//   - req_valid is sampled only in IDLE.
// - Flush:
//   - ic_flush while the owner is I-side (in REQ, WAIT, or the grant cycle) sets drop=1.
//   - The memory transaction still completes, but ic_resp_valid is suppressed.
//   - drop clears on the return to IDLE.
//   - ic_flush in IDLE, or while the owner is D-side, has no effect.
// - Protocol violations:
//   - mem_resp_valid outside WAIT is ignored.
//   - mem_req_ready outside REQ is ignored.
// - Exclusivity: ic_resp_valid and dc_resp_valid are never high together; at most one
//   req_ready is high per cycle.
// TESTING
// - I-only read, addr 0x100, memory returns 0xDEADBEEF after 1 cycle
//   -> ic_req_ready at N+1, mem_req_addr=0x100, ic_resp_valid with 0xDEADBEEF at N+3.
// - I and D valid at once, RR_EN=1, after reset
//   -> I granted first, then D. Repeat the tie -> grants alternate I, D, I, D.
// - RR_EN=0, both requesters valid continuously -> D granted every time; I never granted.
// - D write, addr 0x2000, wdata 0x12345678, mem_req_ready held 0 for 3 cycles
//   -> mem_req_valid and mem fields stable for all 4 cycles; dc_resp_valid after the response.
// - I read in WAIT, ic_flush pulsed, response 0xAA
//   -> ic_resp_valid stays 0; arbiter is IDLE the cycle after the response.
// - reset asserted during WAIT -> next cycle all outputs 0; a later response is ignored;
//   the next request is serviced normally.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares one backing-memory port between the I-cache refill path and the D-cache
// miss/writeback path, one transaction in flight, with fetch-redirect response dropping.
module imem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    input  logic              ic_flush,
    output logic              ic_resp_valid,
    output logic [LINE_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_we,
    input  logic [LINE_W-1:0] dc_req_wdata,
    output logic              dc_req_ready,
    output logic              dc_resp_valid,
    output logic [LINE_W-1:0] dc_resp_data,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              owner_d_r, owner_d_s;
    logic              last_grant_d_r, last_grant_d_s;
    logic              drop_r, drop_s;
    logic              grant_d_s;
    logic              flush_hit_s;

    logic              ic_req_ready_r, ic_req_ready_s;
    logic              ic_resp_valid_r, ic_resp_valid_s;
    logic [LINE_W-1:0] ic_resp_data_r, ic_resp_data_s;
    logic              dc_req_ready_r, dc_req_ready_s;
    logic              dc_resp_valid_r, dc_resp_valid_s;
    logic [LINE_W-1:0] dc_resp_data_r, dc_resp_data_s;
    logic              mem_req_valid_r, mem_req_valid_s;
    logic [ADDR_W-1:0] mem_req_addr_r, mem_req_addr_s;
    logic              mem_req_we_r, mem_req_we_s;
    logic [LINE_W-1:0] mem_req_wdata_r, mem_req_wdata_s;

    assign ic_req_ready  = ic_req_ready_r;
    assign ic_resp_valid = ic_resp_valid_r;
    assign ic_resp_data  = ic_resp_data_r;
    assign dc_req_ready  = dc_req_ready_r;
    assign dc_resp_valid = dc_resp_valid_r;
    assign dc_resp_data  = dc_resp_data_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_we    = mem_req_we_r;
    assign mem_req_wdata = mem_req_wdata_r;

    // Grant selection: a lone requester wins; a tie goes by round-robin or to D
    always_comb begin
        grant_d_s = dc_req_valid;
        if (ic_req_valid && dc_req_valid) begin
            if (RR_EN == 1'b1) begin
                grant_d_s = ~last_grant_d_r;
            end else begin
                grant_d_s = 1'b1;
            end
        end else begin
            grant_d_s = dc_req_valid;
        end
    end

    assign flush_hit_s = ic_flush & ~owner_d_r;

    // Next-state and next-output logic; request fields and response data hold by default
    always_comb begin
        state_s         = state_r;
        owner_d_s       = owner_d_r;
        last_grant_d_s  = last_grant_d_r;
        drop_s          = drop_r;
        ic_req_ready_s  = 1'b0;
        dc_req_ready_s  = 1'b0;
        ic_resp_valid_s = 1'b0;
        dc_resp_valid_s = 1'b0;
        ic_resp_data_s  = ic_resp_data_r;
        dc_resp_data_s  = dc_resp_data_r;
        mem_req_valid_s = mem_req_valid_r;
        mem_req_addr_s  = mem_req_addr_r;
        mem_req_we_s    = mem_req_we_r;
        mem_req_wdata_s = mem_req_wdata_r;

        case (state_r)
            ST_IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    state_s         = ST_REQ;
                    owner_d_s       = grant_d_s;
                    last_grant_d_s  = grant_d_s;
                    mem_req_valid_s = 1'b1;
                    if (grant_d_s) begin
                        dc_req_ready_s  = 1'b1;
                        mem_req_addr_s  = dc_req_addr;
                        mem_req_we_s    = dc_req_we;
                        mem_req_wdata_s = dc_req_wdata;
                        drop_s          = 1'b0;
                    end else begin
                        ic_req_ready_s  = 1'b1;
                        mem_req_addr_s  = ic_req_addr;
                        mem_req_we_s    = 1'b0;
                        mem_req_wdata_s = {LINE_W{1'b0}};
                        // a redirect in the grant cycle already makes this fetch stale
                        drop_s          = ic_flush;
                    end
                end else begin
                    drop_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_s         = ST_WAIT;
                    mem_req_valid_s = 1'b0;
                end else begin
                    mem_req_valid_s = 1'b1;
                end
                if (flush_hit_s) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    state_s = ST_IDLE;
                    drop_s  = 1'b0;
                    if (owner_d_r) begin
                        dc_resp_valid_s = 1'b1;
                        dc_resp_data_s  = mem_resp_data;
                    end else if (!(drop_r || ic_flush)) begin
                        ic_resp_valid_s = 1'b1;
                        ic_resp_data_s  = mem_resp_data;
                    end else begin
                        ic_resp_valid_s = 1'b0;
                    end
                end else if (flush_hit_s) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
            end
            default: begin
                state_s         = ST_IDLE;
                drop_s          = 1'b0;
                mem_req_valid_s = 1'b0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            owner_d_r       <= 1'b0;
            last_grant_d_r  <= 1'b1;
            drop_r          <= 1'b0;
            ic_req_ready_r  <= 1'b0;
            ic_resp_valid_r <= 1'b0;
            ic_resp_data_r  <= {LINE_W{1'b0}};
            dc_req_ready_r  <= 1'b0;
            dc_resp_valid_r <= 1'b0;
            dc_resp_data_r  <= {LINE_W{1'b0}};
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
            mem_req_we_r    <= 1'b0;
            mem_req_wdata_r <= {LINE_W{1'b0}};
        end else begin
            state_r         <= state_s;
            owner_d_r       <= owner_d_s;
            last_grant_d_r  <= last_grant_d_s;
            drop_r          <= drop_s;
            ic_req_ready_r  <= ic_req_ready_s;
            ic_resp_valid_r <= ic_resp_valid_s;
            ic_resp_data_r  <= ic_resp_data_s;
            dc_req_ready_r  <= dc_req_ready_s;
            dc_resp_valid_r <= dc_resp_valid_s;
            dc_resp_data_r  <= dc_resp_data_s;
            mem_req_valid_r <= mem_req_valid_s;
            mem_req_addr_r  <= mem_req_addr_s;
            mem_req_we_r    <= mem_req_we_s;
            mem_req_wdata_r <= mem_req_wdata_s;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed, table-driven bench for imem_port_arbiter: a round-robin instance driven
// cycle by cycle from a vector table, plus a fixed-priority instance and reset sequences.
module tb_imem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        ic_req_valid, ic_flush, dc_req_valid, dc_req_we;
    logic [31:0] ic_req_addr, dc_req_addr, dc_req_wdata, mem_resp_data;
    logic        mem_req_ready, mem_resp_valid;
    logic        ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] ic_resp_data, dc_resp_data, mem_req_addr, mem_req_wdata;

    // fixed-priority instance has its own handshake inputs
    logic        ic_v2, dc_v2, mrr2, rv2, fl2;
    logic        ic_rr2, ic_rv2, dc_rr2, dc_rv2, mv2, mwe2;
    logic [31:0] ic_rd2, dc_rd2, ma2, mwd2;

    int n_tests = 0;
    int n_fail  = 0;

    imem_port_arbiter #(.ADDR_W(32), .LINE_W(32), .RR_EN(1'b1)) dut (
        .clock(clock), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_flush(ic_flush), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    imem_port_arbiter #(.ADDR_W(32), .LINE_W(32), .RR_EN(1'b0)) dut_fp (
        .clock(clock), .reset(reset),
        .ic_req_valid(ic_v2), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_rr2),
        .ic_flush(fl2), .ic_resp_valid(ic_rv2), .ic_resp_data(ic_rd2),
        .dc_req_valid(dc_v2), .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
        .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_rr2),
        .dc_resp_valid(dc_rv2), .dc_resp_data(dc_rd2),
        .mem_req_valid(mv2), .mem_req_addr(ma2), .mem_req_we(mwe2),
        .mem_req_wdata(mwd2), .mem_req_ready(mrr2),
        .mem_resp_valid(rv2), .mem_resp_data(mem_resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ic_v;
        logic [31:0] ia;
        logic        fl;
        logic        dc_v;
        logic [31:0] da;
        logic        dwe;
        logic [31:0] dwd;
        logic        mrr;
        logic        rv;
        logic [31:0] rd;
        logic [133:0] exp_out;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ic_v, input logic [31:0] ia, input logic fl,
                       input logic dc_v, input logic [31:0] da, input logic dwe,
                       input logic [31:0] dwd, input logic mrr, input logic rv,
                       input logic [31:0] rd,
                       input logic icrr, input logic icrv, input logic [31:0] icrd,
                       input logic dcrr, input logic dcrv, input logic [31:0] dcrd,
                       input logic mv, input logic [31:0] ma, input logic mwe,
                       input logic [31:0] mwd);
        vec_t v;
        v.ic_v = ic_v; v.ia = ia; v.fl = fl; v.dc_v = dc_v; v.da = da; v.dwe = dwe;
        v.dwd = dwd; v.mrr = mrr; v.rv = rv; v.rd = rd;
        v.exp_out = {icrr, icrv, icrd, dcrr, dcrv, dcrd, mv, ma, mwe, mwd};
        vq.push_back(v);
    endtask

    function automatic logic [133:0] main_out();
        return {ic_req_ready, ic_resp_valid, ic_resp_data, dc_req_ready, dc_resp_valid,
                dc_resp_data, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata};
    endfunction

    function automatic logic [133:0] fp_out();
        return {ic_rr2, ic_rv2, ic_rd2, dc_rr2, dc_rv2, dc_rd2, mv2, ma2, mwe2, mwd2};
    endfunction

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ic_req_valid = 1'b0; ic_req_addr = 32'h0; ic_flush = 1'b0;
        dc_req_valid = 1'b0; dc_req_addr = 32'h0; dc_req_we = 1'b0; dc_req_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    endtask

    initial begin
        // Tie arbitration I,D,I,D then single I read with 1-cycle memory
        add(1'b1,32'h10,1'b0,1'b1,32'h20,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,32'h10,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b1,32'h20,1'b0,32'h0,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h10,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b1,32'h20,1'b0,32'h0,1'b0,1'b1,32'h11111111,  1'b0,1'b1,32'h11111111,1'b0,1'b0,32'h0,1'b0,32'h10,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b1,32'h20,1'b0,32'h0,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h11111111,1'b1,1'b0,32'h0,1'b1,32'h20,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,1'b0,32'h11111111,1'b0,1'b0,32'h0,1'b0,32'h20,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h22222222,   1'b0,1'b0,32'h11111111,1'b0,1'b1,32'h22222222,1'b0,32'h20,1'b0,32'h0);
        add(1'b1,32'h10,1'b0,1'b1,32'h20,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h11111111,1'b0,1'b0,32'h22222222,1'b1,32'h10,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b1,32'h20,1'b0,32'h0,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h11111111,1'b0,1'b0,32'h22222222,1'b0,32'h10,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b1,32'h20,1'b0,32'h0,1'b0,1'b1,32'h33333333,  1'b0,1'b1,32'h33333333,1'b0,1'b0,32'h22222222,1'b0,32'h10,1'b0,32'h0);
        add(1'b1,32'h10,1'b0,1'b1,32'h20,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h33333333,1'b1,1'b0,32'h22222222,1'b1,32'h20,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,1'b0,32'h33333333,1'b0,1'b0,32'h22222222,1'b0,32'h20,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h44444444,   1'b0,1'b0,32'h33333333,1'b0,1'b1,32'h44444444,1'b0,32'h20,1'b0,32'h0);
        add(1'b1,32'h100,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h33333333,1'b0,1'b0,32'h44444444,1'b1,32'h100,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,1'b0,32'h33333333,1'b0,1'b0,32'h44444444,1'b0,32'h100,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'hDEADBEEF,   1'b0,1'b1,32'hDEADBEEF,1'b0,1'b0,32'h44444444,1'b0,32'h100,1'b0,32'h0);
        // stray response in IDLE is ignored
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h99999999,   1'b0,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h44444444,1'b0,32'h100,1'b0,32'h0);
        // D write with memory stalling 3 cycles
        add(1'b0,32'h0,1'b0,1'b1,32'h2000,1'b1,32'h12345678,1'b0,1'b0,32'h0, 1'b0,1'b0,32'hDEADBEEF,1'b1,1'b0,32'h44444444,1'b1,32'h2000,1'b1,32'h12345678);
        for (int i = 0; i < 3; i++) begin
            add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,      1'b0,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h44444444,1'b1,32'h2000,1'b1,32'h12345678);
        end
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h44444444,1'b0,32'h2000,1'b1,32'h12345678);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h0000ACED,   1'b0,1'b0,32'hDEADBEEF,1'b0,1'b1,32'h0000ACED,1'b0,32'h2000,1'b1,32'h12345678);
        // I read flushed in WAIT, then a clean I read straight after
        add(1'b1,32'h300,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0000ACED,1'b1,32'h300,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0000ACED,1'b0,32'h300,1'b0,32'h0);
        add(1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0000ACED,1'b0,32'h300,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h000000AA,   1'b0,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0000ACED,1'b0,32'h300,1'b0,32'h0);
        add(1'b1,32'h400,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0000ACED,1'b1,32'h400,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0000ACED,1'b0,32'h400,1'b0,32'h0);
        add(1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h00000055,   1'b0,1'b1,32'h00000055,1'b0,1'b0,32'h0000ACED,1'b0,32'h400,1'b0,32'h0);
        // flush held throughout a D read has no effect
        add(1'b0,32'h0,1'b1,1'b1,32'h500,1'b0,32'h0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h00000055,1'b1,1'b0,32'h0000ACED,1'b1,32'h500,1'b0,32'h0);
        add(1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,1'b0,32'h00000055,1'b0,1'b0,32'h0000ACED,1'b0,32'h500,1'b0,32'h0);
        add(1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,32'h00000066,   1'b0,1'b0,32'h00000055,1'b0,1'b1,32'h00000066,1'b0,32'h500,1'b0,32'h0);

        idle_inputs();
        ic_v2 = 1'b0; dc_v2 = 1'b0; mrr2 = 1'b0; rv2 = 1'b0; fl2 = 1'b0;
        reset = 1'b1;
        tick(); tick(); tick();
        check("reset_main", main_out(), 134'h0);
        check("reset_fp", fp_out(), 134'h0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            ic_req_valid = vq[i].ic_v; ic_req_addr = vq[i].ia; ic_flush = vq[i].fl;
            dc_req_valid = vq[i].dc_v; dc_req_addr = vq[i].da; dc_req_we = vq[i].dwe;
            dc_req_wdata = vq[i].dwd; mem_req_ready = vq[i].mrr;
            mem_resp_valid = vq[i].rv; mem_resp_data = vq[i].rd;
            tick();
            check($sformatf("row%0d", i), main_out(), vq[i].exp_out);
        end
        idle_inputs();

        // Fixed priority: both requesting continuously, D wins every time
        for (int i = 0; i < 3; i++) begin
            ic_v2 = 1'b1; dc_v2 = 1'b1; mrr2 = 1'b1; rv2 = 1'b0;
            tick();
            check($sformatf("fp_grant%0d", i), {ic_rr2, dc_rr2}, 2'b01);
            tick();
            check($sformatf("fp_req%0d", i), {ic_rr2, dc_rr2}, 2'b00);
            rv2 = 1'b1; mem_resp_data = 32'hC0DE0000 + 32'(i);
            tick();
            check($sformatf("fp_resp%0d", i), {ic_rv2, dc_rv2, dc_rd2}, {2'b01, 32'hC0DE0000 + 32'(i)});
            rv2 = 1'b0;
        end
        ic_v2 = 1'b0; dc_v2 = 1'b0; mrr2 = 1'b0;

        // Reset during WAIT abandons the I read and restores last_grant to D
        ic_req_valid = 1'b1; ic_req_addr = 32'h700; mem_req_ready = 1'b1;
        tick();
        ic_req_valid = 1'b0;
        tick();
        check("pre_reset_wait", {mem_req_valid, mem_req_addr}, {1'b0, 32'h700});
        mem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        check("reset_in_wait", main_out(), 134'h0);
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        tick();
        check("late_resp_ignored", main_out(), 134'h0);
        mem_resp_valid = 1'b0;
        ic_req_valid = 1'b1; ic_req_addr = 32'h900;
        dc_req_valid = 1'b1; dc_req_addr = 32'h800;
        tick();
        check("post_reset_tie", {ic_req_ready, dc_req_ready, mem_req_valid, mem_req_addr}, {3'b101, 32'h900});
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h88;
        tick();
        check("post_reset_resp", {ic_resp_valid, dc_resp_valid, ic_resp_data}, {2'b10, 32'h88});
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
